countdown_timer: RTL and testbench

Count-down companion to the stopwatch. The user loads a minutes:seconds value with two increment buttons, then starts the timer. It counts down once per second to 00:00 and raises an alarm. Digits drive the same four seven-segment outputs through the team's NumDisplay decoder. Inputs come from debounced board buttons.

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 164 ++++++++++++++++
 tb/tb_countdown_timer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Button inputs and display/status outputs of the countdown timer.
// The master side drives the buttons; the slave side is the timer itself.
interface countdown_timer_if;
    logic       start_stop;
    logic       inc_min;
    logic       inc_sec;
    logic [6:0] firstSegment;
    logic [6:0] secondSegment;
    logic [6:0] thirdSegment;
    logic [6:0] fourthSegment;
    logic       running;
    logic       alarm;

    modport master (
        output start_stop, inc_min, inc_sec,
        input  firstSegment, secondSegment, thirdSegment, fourthSegment, running, alarm
    );

    modport slave (
        input  start_stop, inc_min, inc_sec,
        output firstSegment, secondSegment, thirdSegment, fourthSegment, running, alarm
    );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with button load, start/pause/resume and an alarm at 00:00.
// The four BCD digits drive active-low seven-segment outputs (NumDisplay encoding).
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  tmr
);
    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_mt, r_st;
    logic [3:0]    r_mo, r_so;
    logic          r_prev_ss, r_prev_min, r_prev_sec;
    logic          r_running, r_alarm;

    logic          w_ss_edge, w_min_edge, w_sec_edge;
    logic          w_is_zero, w_is_one, w_term;
    logic [2:0]    w_dec_mt, w_dec_st, w_inc_mt, w_inc_st;
    logic [3:0]    w_dec_mo, w_dec_so, w_inc_mo, w_inc_so;

    assign w_ss_edge  = tmr.start_stop & ~r_prev_ss;
    assign w_min_edge = tmr.inc_min    & ~r_prev_min;
    assign w_sec_edge = tmr.inc_sec    & ~r_prev_sec;
    assign w_is_zero  = (r_mt == 3'd0) && (r_mo == 4'd0) && (r_st == 3'd0) && (r_so == 4'd0);
    assign w_is_one   = (r_mt == 3'd0) && (r_mo == 4'd0) && (r_st == 3'd0) && (r_so == 4'd1);
    assign w_term     = (r_presc == TERM);

    // One-second BCD decrement with borrow; only used when time is non-zero.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so - 4'd1;
        if (r_so == 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 3'd1;
            if (r_st == 3'd0) begin
                w_dec_st = 3'd5;
                w_dec_mo = r_mo - 4'd1;
                if (r_mo == 4'd0) begin
                    w_dec_mo = 4'd9;
                    w_dec_mt = r_mt - 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_inc_mt = r_mt;
        w_inc_mo = r_mo + 4'd1;
        if (r_mo == 4'd9) begin
            w_inc_mo = 4'd0;
            w_inc_mt = (r_mt == 3'd5) ? 3'd0 : r_mt + 3'd1;
        end
        w_inc_st = r_st;
        w_inc_so = r_so + 4'd1;
        if (r_so == 4'd9) begin
            w_inc_so = 4'd0;
            w_inc_st = (r_st == 3'd5) ? 3'd0 : r_st + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_mt       <= '0;
            r_mo       <= '0;
            r_st       <= '0;
            r_so       <= '0;
            r_running  <= 1'b0;
            r_alarm    <= 1'b0;
            r_prev_ss  <= 1'b1;
            r_prev_min <= 1'b1;
            r_prev_sec <= 1'b1;
        end else begin
            r_prev_ss  <= tmr.start_stop;
            r_prev_min <= tmr.inc_min;
            r_prev_sec <= tmr.inc_sec;
            case (r_state)
                IDLE: begin
                    if (w_ss_edge) begin
                        if (!w_is_zero) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                            r_presc   <= '0;
                        end
                    end else begin
                        if (w_min_edge) begin
                            r_mt <= w_inc_mt;
                            r_mo <= w_inc_mo;
                        end
                        if (w_sec_edge) begin
                            r_st <= w_inc_st;
                            r_so <= w_inc_so;
                        end
                    end
                end
                RUN: begin
                    // Pause takes priority over a coincident terminal count.
                    if (w_ss_edge) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_term) begin
                        r_presc <= '0;
                        r_mt    <= w_dec_mt;
                        r_mo    <= w_dec_mo;
                        r_st    <= w_dec_st;
                        r_so    <= w_dec_so;
                        if (w_is_one) begin
                            r_state   <= ALARM;
                            r_running <= 1'b0;
                            r_alarm   <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                PAUSE: begin
                    if (w_ss_edge) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                ALARM: begin
                    if (w_ss_edge) begin
                        r_state <= IDLE;
                        r_alarm <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign tmr.firstSegment  = seg7({1'b0, r_mt});
    assign tmr.secondSegment = seg7(r_mo);
    assign tmr.thirdSegment  = seg7({1'b0, r_st});
    assign tmr.fourthSegment = seg7(r_so);
    assign tmr.running       = r_running;
    assign tmr.alarm         = r_alarm;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC=4; stimulus queues expected
// display/status snapshots, a negedge monitor pops and compares them.
module tb_countdown_timer;
    logic clk = 1'b0;
    logic reset = 1'b0;

    countdown_timer_if tif ();

    countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .tmr   (tif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [29:0] val;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: ref_seg = 7'b1000000;
            1: ref_seg = 7'b1111001;
            2: ref_seg = 7'b0100100;
            3: ref_seg = 7'b0110000;
            4: ref_seg = 7'b0011001;
            5: ref_seg = 7'b0010010;
            6: ref_seg = 7'b0000010;
            7: ref_seg = 7'b1111000;
            8: ref_seg = 7'b0000000;
            9: ref_seg = 7'b0010000;
            default: ref_seg = 7'bxxxxxxx;
        endcase
    endfunction

    task automatic expect_state(input string name, input int mt, input int mo, input int st,
                                input int so, input logic run, input logic alm);
        exp_t e;
        e.name = name;
        e.val  = {ref_seg(mt), ref_seg(mo), ref_seg(st), ref_seg(so), run, alm};
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [29:0] act;
            e   = exp_q.pop_front();
            act = {tif.firstSegment, tif.secondSegment, tif.thirdSegment,
                   tif.fourthSegment, tif.running, tif.alarm};
            compared++;
            if (act !== e.val) begin
                mismatched++;
                $display("FAIL %s: got %h, want %h", e.name, act, e.val);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        tif.start_stop = 1'b1; tick(1);
        tif.start_stop = 1'b0; tick(1);
    endtask

    task automatic press_min();
        tif.inc_min = 1'b1; tick(1);
        tif.inc_min = 1'b0; tick(1);
    endtask

    task automatic press_sec();
        tif.inc_sec = 1'b1; tick(1);
        tif.inc_sec = 1'b0; tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b0; tick(1);
        reset = 1'b1; tick(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tif.start_stop = 1'b0;
        tif.inc_min    = 1'b0;
        tif.inc_sec    = 1'b0;
        reset          = 1'b0;
        tick(2);
        expect_state("reset", 0, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1);

        press_start();
        expect_state("start_at_zero", 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (59) press_sec();
        expect_state("sec_59", 0, 0, 5, 9, 1'b0, 1'b0);
        repeat (2) press_sec();
        expect_state("sec_wrap", 0, 0, 0, 1, 1'b0, 1'b0);

        do_reset();
        tif.inc_min = 1'b1; tif.inc_sec = 1'b1; tick(1);
        tif.inc_min = 1'b0; tif.inc_sec = 1'b0; tick(1);
        expect_state("simul_inc", 0, 1, 0, 1, 1'b0, 1'b0);
        repeat (59) press_min();
        expect_state("min_wrap", 0, 0, 0, 1, 1'b0, 1'b0);

        // Countdown 01:00 -> 00:00
        do_reset();
        press_min();
        tif.start_stop = 1'b1; tick(1);
        tif.start_stop = 1'b0;
        expect_state("run_enter", 0, 1, 0, 0, 1'b1, 1'b0);
        tick(3);
        expect_state("pre_first_dec", 0, 1, 0, 0, 1'b1, 1'b0);
        tick(1);
        expect_state("first_dec", 0, 0, 5, 9, 1'b1, 1'b0);
        tick(235);
        expect_state("one_left", 0, 0, 0, 1, 1'b1, 1'b0);
        tick(1);
        expect_state("alarm", 0, 0, 0, 0, 1'b0, 1'b1);
        press_sec();
        expect_state("alarm_inc_ignored", 0, 0, 0, 0, 1'b0, 1'b1);
        press_start();
        expect_state("ack", 0, 0, 0, 0, 1'b0, 1'b0);

        // Pause / resume from 00:05
        repeat (5) press_sec();
        tif.start_stop = 1'b1; tick(1);
        tif.start_stop = 1'b0; tick(2);
        tif.start_stop = 1'b1; tick(1);
        expect_state("pause", 0, 0, 0, 5, 1'b0, 1'b0);
        tif.start_stop = 1'b0; tick(20);
        expect_state("paused_hold", 0, 0, 0, 5, 1'b0, 1'b0);
        tif.start_stop = 1'b1; tick(1);
        tif.start_stop = 1'b0;
        expect_state("resume", 0, 0, 0, 5, 1'b1, 1'b0);
        tick(1);
        expect_state("resume_plus1", 0, 0, 0, 5, 1'b1, 1'b0);
        tick(1);
        expect_state("resume_dec", 0, 0, 0, 4, 1'b1, 1'b0);
        tick(3);
        tif.start_stop = 1'b1; tick(1);
        expect_state("pause_wins_term", 0, 0, 0, 4, 1'b0, 1'b0);
        tif.start_stop = 1'b0; tick(3);
        tif.start_stop = 1'b1; tick(1);
        tif.start_stop = 1'b0;
        expect_state("resume_at_term", 0, 0, 0, 4, 1'b1, 1'b0);
        tick(1);
        expect_state("held_term_dec", 0, 0, 0, 3, 1'b1, 1'b0);
        press_min();
        expect_state("run_inc_ignored", 0, 0, 0, 3, 1'b1, 1'b0);

        // Reset mid-RUN with buttons active; start_stop held through release
        reset = 1'b0; tif.start_stop = 1'b1; tif.inc_sec = 1'b1; tick(1);
        expect_state("reset_mid_run", 0, 0, 0, 0, 1'b0, 1'b0);
        tif.inc_sec = 1'b0; reset = 1'b1; tick(1);
        repeat (2) press_sec();
        expect_state("held_no_start", 0, 0, 0, 2, 1'b0, 1'b0);
        tif.start_stop = 1'b0; tick(1);
        tif.start_stop = 1'b1; tick(1);
        expect_state("held_rearm", 0, 0, 0, 2, 1'b1, 1'b0);
        tif.start_stop = 1'b0; tick(1);

        do_reset();
        repeat (3) press_sec();
        tif.start_stop = 1'b1; tif.inc_sec = 1'b1; tick(1);
        expect_state("start_priority", 0, 0, 0, 3, 1'b1, 1'b0);
        tif.start_stop = 1'b0; tif.inc_sec = 1'b0; tick(1);

        tick(2);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
